hex_sprite_renderer: RTL and testbench
======================================

HEX_SPRITE_RENDERER -- requirements
Module: hex_sprite_renderer

Interface
REQ-001 Parameter FB_W, default 40, SHALL set the framebuffer width in pixels.
REQ-002 Parameter FB_H, default 30, SHALL set the framebuffer height in pixels.
REQ-003 Parameter NUM_SPRITES, default 3, SHALL set the number of independent two-digit hex sprites.
REQ-004 Parameter DIGIT_GAP, default 2, SHALL set the blank columns between a sprite's two glyphs.
REQ-005 Port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: request to render one frame.
REQ-008 Port values, input, 8*NUM_SPRITES bits: sprite i byte at [8i+7:8i]; high nibble is the left glyph.
REQ-009 Port xpos, input, 6*NUM_SPRITES bits: sprite i left-glyph left column at [6i+5:6i].
REQ-010 Port ypos, input, 5*NUM_SPRITES bits: sprite i top row at [5i+4:5i].
REQ-011 Port enable, input, NUM_SPRITES bits: bit i high means sprite i is drawn.
REQ-012 Port framebuffer, output, FB_W*FB_H bits: pixel (x,y) at bit y*FB_W+x, registered.
REQ-013 Port busy, output, 1 bit: high in every state other than IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when framebuffer has been updated.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, DRAW and SWAP.
REQ-016 In IDLE, start high SHALL latch values/xpos/ypos/enable into internal registers and move to CLEAR; start in any other state SHALL be ignored.
REQ-017 CLEAR SHALL zero one back-buffer row per cycle, rows 0..FB_H-1, FB_H cycles total, then go to DRAW.
REQ-018 DRAW SHALL spend exactly 5 cycles per sprite, in order 0..NUM_SPRITES-1 and glyph rows 0..4, writing both glyphs' 3-pixel row per cycle, then go to SWAP.
REQ-019 Disabled sprites SHALL still consume their 5 DRAW cycles but write nothing, so latency is constant.
REQ-020 Writes SHALL OR into the back buffer, so overlapping sprites union.
REQ-021 Glyph row r (0 = top) SHALL be font bits [14-3r:12-3r]. Row bit 2 SHALL map to column x, bit 1 to x+1, and bit 0 to x+2.
REQ-022 The left glyph SHALL start at xpos, the right glyph at xpos+3+DIGIT_GAP, and rows SHALL start at ypos+r.
REQ-023 Pixels with column >= FB_W or row >= FB_H SHALL be dropped: no wrap-around and no write to other rows.
REQ-024 SWAP SHALL copy the back buffer to framebuffer in one cycle and assert done for that edge only, then return to IDLE.
REQ-025 Latency from the start-accepting edge to the done edge SHALL be FB_H+5*NUM_SPRITES+1 cycles (46 with defaults).
REQ-026 framebuffer SHALL hold its value between SWAPs and never expose a partially drawn frame.
REQ-027 Input changes after the start-accepting edge SHALL NOT affect the frame being rendered.

Reset
REQ-028 Reset high SHALL immediately force IDLE, framebuffer=0, back buffer=0, busy=0, done=0 and latched inputs=0, including during any state.
REQ-029 After reset deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Structure
REQ-030 A shared package SHALL hold the 16x15-bit hex font constant (e.g. '0'=111101101101111, '1'=010010010010010, '6'=111100111101111, 'C'=111100100100111), the glyph dimensions 3x5, and the FSM state typedef.
REQ-031 A sub-module hex_glyph_rom SHALL map a 4-bit nibble and 3-bit row to the 3-bit row pattern, combinationally.

Verification
REQ-032 Sprite0=0x6C, x=16, y=2, others disabled, start -> done after 46 cycles; bits 98:96=111, 103:101=111, 136 set, 137 and 138 clear, 141 set.
REQ-033 Sprite0=0x88 at x=38, y=28 -> only columns 38-39 of rows 28-29 set; rows 0-27 and all other columns zero, no wrap.
REQ-034 Sprites 0 and 1 both 0x00 at x=0, y=0 and x=1, y=0 -> row 0 bits 0..3 and 5..8 set (OR union), done once.
REQ-035 start pulsed again at cycles 10 and 45 of a render -> both ignored, exactly one done; idle cycle, then a new start is accepted.
REQ-036 Reset asserted at DRAW cycle 3 -> framebuffer=0, busy=0 immediately; the next start renders a full correct frame.
REQ-037 Inputs changed one cycle after start -> the rendered frame reflects the originally latched values only.

Source files
------------

// File: rtl/hex_sprite_renderer_pkg.sv
// Shared definitions for the hex sprite renderer: 3x5 hex font, glyph geometry, FSM states.
// Latency: n/a (constants, types and a pure combinational helper only).
// Backpressure: n/a.
package hex_sprite_renderer_pkg;

    localparam int GLYPH_W = 3;
    localparam int GLYPH_H = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    // 15 bits per glyph, top row in [14:12]; within a row bit 2 is the leftmost pixel.
    localparam logic [14:0] HEX_FONT [16] = '{
        15'b111_101_101_101_111, // 0
        15'b010_010_010_010_010, // 1
        15'b111_001_111_100_111, // 2
        15'b111_001_111_001_111, // 3
        15'b101_101_111_001_001, // 4
        15'b111_100_111_001_111, // 5
        15'b111_100_111_101_111, // 6
        15'b111_001_001_001_001, // 7
        15'b111_101_111_101_111, // 8
        15'b111_101_111_001_111, // 9
        15'b111_101_111_101_101, // A
        15'b110_101_110_101_110, // B
        15'b111_100_100_100_111, // C
        15'b110_101_101_101_110, // D
        15'b111_100_111_100_111, // E
        15'b111_100_111_100_100  // F
    };

    // Row r of a glyph lives at bits [14-3r:12-3r]; rows past the glyph height are blank.
    function automatic logic [2:0] font_row(input logic [3:0] nibble, input logic [2:0] row);
        logic [14:0] glyph;
        glyph = HEX_FONT[nibble];
        if (int'(row) >= GLYPH_H) begin
            return 3'b000;
        end
        return glyph[3 * (GLYPH_H - 1 - int'(row)) +: 3];
    endfunction

endpackage

// File: rtl/hex_sprite_renderer_if.sv
// Bundles the renderer's request inputs and frame outputs.
// Latency: n/a (wiring only).
// Backpressure: none; start is ignored by the slave while it is busy.
// Ports: start/values/xpos/ypos/enable driven by master; framebuffer/busy/done driven by slave.
interface hex_sprite_renderer_if #(
    parameter int FB_W        = 40,
    parameter int FB_H        = 30,
    parameter int NUM_SPRITES = 3
);
    logic                     start;
    logic [8*NUM_SPRITES-1:0] values;
    logic [6*NUM_SPRITES-1:0] xpos;
    logic [5*NUM_SPRITES-1:0] ypos;
    logic [NUM_SPRITES-1:0]   enable;
    logic [FB_W*FB_H-1:0]     framebuffer;
    logic                     busy;
    logic                     done;

    modport master (
        output start, values, xpos, ypos, enable,
        input  framebuffer, busy, done
    );

    modport slave (
        input  start, values, xpos, ypos, enable,
        output framebuffer, busy, done
    );
endinterface

// File: rtl/hex_sprite_renderer_glyph_rom.sv
// Combinational hex glyph ROM: nibble + glyph row -> 3-pixel row pattern.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: n/a.
// Ports: nibble (hex digit), row (0 = top), row_bits (bit 2 = leftmost pixel).
module hex_glyph_rom
    import hex_sprite_renderer_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic [2:0] row,
    output logic [2:0] row_bits
);
    always_comb begin
        row_bits = font_row(nibble, row);
    end
endmodule

// File: rtl/hex_sprite_renderer.sv
// Renders NUM_SPRITES two-digit hex sprites into a double-buffered 1-bpp framebuffer.
// Latency: FB_H + 5*NUM_SPRITES + 1 cycles from the start-accepting edge to done.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clock, reset (async, active-high); bus carries start/values/xpos/ypos/enable in,
//        framebuffer/busy/done out.
module hex_sprite_renderer
    import hex_sprite_renderer_pkg::*;
#(
    parameter int FB_W        = 40,
    parameter int FB_H        = 30,
    parameter int NUM_SPRITES = 3,
    parameter int DIGIT_GAP   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    hex_sprite_renderer_if.slave  bus
);

    localparam int ROW_W = (FB_H > 1) ? $clog2(FB_H) : 1;
    localparam int COL_W = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int SPR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    state_t                    state_q, state_d;
    logic [8*NUM_SPRITES-1:0]  values_q, values_d;
    logic [6*NUM_SPRITES-1:0]  xpos_q, xpos_d;
    logic [5*NUM_SPRITES-1:0]  ypos_q, ypos_d;
    logic [NUM_SPRITES-1:0]    enable_q, enable_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [SPR_W-1:0]          spr_q, spr_d;
    logic [2:0]                grow_q, grow_d;
    logic [FB_H-1:0][FB_W-1:0] back_q, back_d;
    logic [FB_W*FB_H-1:0]      fb_q, fb_d;
    logic                      done_q, done_d;

    // Fields of the sprite currently being drawn.
    logic [7:0] cur_val;
    logic [5:0] cur_x;
    logic [4:0] cur_y;
    logic       cur_en;
    logic [2:0] left_bits;
    logic [2:0] right_bits;

    always_comb begin
        cur_val = '0;
        cur_x   = '0;
        cur_y   = '0;
        cur_en  = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (int'(spr_q) == i) begin
                cur_val = values_q[8*i +: 8];
                cur_x   = xpos_q[6*i +: 6];
                cur_y   = ypos_q[5*i +: 5];
                cur_en  = enable_q[i];
            end
        end
    end

    hex_glyph_rom u_rom_left (
        .nibble   (cur_val[7:4]),
        .row      (grow_q),
        .row_bits (left_bits)
    );

    hex_glyph_rom u_rom_right (
        .nibble   (cur_val[3:0]),
        .row      (grow_q),
        .row_bits (right_bits)
    );

    always_comb begin
        int py;
        int lx;
        int rx;

        state_d  = state_q;
        values_d = values_q;
        xpos_d   = xpos_q;
        ypos_d   = ypos_q;
        enable_d = enable_q;
        row_d    = row_q;
        spr_d    = spr_q;
        grow_d   = grow_q;
        back_d   = back_q;
        fb_d     = fb_q;
        done_d   = 1'b0;
        py       = 0;
        lx       = 0;
        rx       = 0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    values_d = bus.values;
                    xpos_d   = bus.xpos;
                    ypos_d   = bus.ypos;
                    enable_d = bus.enable;
                    row_d    = '0;
                    state_d  = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                back_d[row_q] = '0;
                if (int'(row_q) == FB_H - 1) begin
                    row_d   = '0;
                    spr_d   = '0;
                    grow_d  = '0;
                    state_d = ST_DRAW;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end

            ST_DRAW: begin
                // Disabled sprites still walk their five rows so latency never varies.
                py = int'(cur_y) + int'(grow_q);
                if (cur_en && (py < FB_H)) begin
                    for (int k = 0; k < GLYPH_W; k++) begin
                        lx = int'(cur_x) + k;
                        rx = int'(cur_x) + GLYPH_W + DIGIT_GAP + k;
                        // Off-screen columns are dropped rather than wrapped into the next row.
                        if (left_bits[GLYPH_W-1-k] && (lx < FB_W)) begin
                            back_d[py[ROW_W-1:0]][lx[COL_W-1:0]] = 1'b1;
                        end
                        if (right_bits[GLYPH_W-1-k] && (rx < FB_W)) begin
                            back_d[py[ROW_W-1:0]][rx[COL_W-1:0]] = 1'b1;
                        end
                    end
                end

                if (int'(grow_q) == GLYPH_H - 1) begin
                    grow_d = '0;
                    if (int'(spr_q) == NUM_SPRITES - 1) begin
                        state_d = ST_SWAP;
                    end else begin
                        spr_d = spr_q + 1'b1;
                    end
                end else begin
                    grow_d = grow_q + 3'd1;
                end
            end

            ST_SWAP: begin
                // Row y of the back buffer packs to bits [y*FB_W +: FB_W], matching the output map.
                fb_d    = back_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            values_q <= '0;
            xpos_q   <= '0;
            ypos_q   <= '0;
            enable_q <= '0;
            row_q    <= '0;
            spr_q    <= '0;
            grow_q   <= '0;
            back_q   <= '0;
            fb_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            values_q <= values_d;
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            enable_q <= enable_d;
            row_q    <= row_d;
            spr_q    <= spr_d;
            grow_q   <= grow_d;
            back_q   <= back_d;
            fb_q     <= fb_d;
            done_q   <= done_d;
        end
    end

    assign bus.framebuffer = fb_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;

endmodule

// File: tb/tb_hex_sprite_renderer.sv
module tb_hex_sprite_renderer;

    localparam int W   = 40;
    localparam int H   = 30;
    localparam int N   = 3;
    localparam int GAP = 2;
    localparam int FB  = W * H;
    localparam int LAT = H + 5 * N + 1;

    // Reference glyphs, written as five 3-pixel rows top to bottom, leftmost pixel first.
    localparam logic [14:0] FONT [16] = '{
        15'b111_101_101_101_111, 15'b010_010_010_010_010,
        15'b111_001_111_100_111, 15'b111_001_111_001_111,
        15'b101_101_111_001_001, 15'b111_100_111_001_111,
        15'b111_100_111_101_111, 15'b111_001_001_001_001,
        15'b111_101_111_101_111, 15'b111_101_111_001_111,
        15'b111_101_111_101_101, 15'b110_101_110_101_110,
        15'b111_100_100_100_111, 15'b110_101_101_101_110,
        15'b111_100_111_100_111, 15'b111_100_111_100_100
    };

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hex_sprite_renderer_if #(.FB_W(W), .FB_H(H), .NUM_SPRITES(N)) bus_i ();

    hex_sprite_renderer #(
        .FB_W(W), .FB_H(H), .NUM_SPRITES(N), .DIGIT_GAP(GAP)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus_i)
    );

    // Picture a frame directly: stamp every lit font pixel, clip anything off the screen.
    function automatic logic [FB-1:0] model(input logic [8*N-1:0] v, input logic [6*N-1:0] xs,
                                            input logic [5*N-1:0] ys, input logic [N-1:0] en);
        logic [FB-1:0] f;
        logic [3:0]    nib;
        int            gx, gy, px, py;
        f = '0;
        for (int s = 0; s < N; s++) begin
            if (en[s]) begin
                for (int d = 0; d < 2; d++) begin
                    nib = (d == 0) ? v[8*s+4 +: 4] : v[8*s +: 4];
                    gx  = int'(xs[6*s +: 6]) + d * (3 + GAP);
                    gy  = int'(ys[5*s +: 5]);
                    for (int r = 0; r < 5; r++) begin
                        for (int c = 0; c < 3; c++) begin
                            if (FONT[nib][14 - 3*r - c]) begin
                                px = gx + c;
                                py = gy + r;
                                if (px < W && py < H) f[py*W + px] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        return f;
    endfunction

    function automatic logic [FB-1:0] model_now();
        return model(bus_i.values, bus_i.xpos, bus_i.ypos, bus_i.enable);
    endfunction

    task automatic set_sprite(input int i, input logic [7:0] v, input logic [5:0] x,
                              input logic [4:0] y, input logic e);
        bus_i.values[8*i +: 8] = v;
        bus_i.xpos[6*i +: 6]   = x;
        bus_i.ypos[5*i +: 5]   = y;
        bus_i.enable[i]        = e;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            set_sprite(i, 8'($urandom), 6'($urandom_range(0, 45)), 5'($urandom_range(0, 31)),
                       1'($urandom));
        end
    endtask

    // Fire one start (caller sits 1 time unit after an edge, DUT idle) and watch 200 cycles.
    // lat = edges from the start edge to the first done (-1 if none); early = the visible
    // frame moved before done; gap = busy dropped before done.
    task automatic render(input bit scramble, output int lat, output int ndone,
                          output bit early, output bit gap);
        logic [FB-1:0] prev;
        prev = bus_i.framebuffer;
        lat = -1; ndone = 0; early = 1'b0; gap = 1'b0;
        bus_i.start = 1'b1;
        @(posedge clk); #1;
        bus_i.start = 1'b0;
        if (scramble) rand_inputs();
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (bus_i.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end else if (lat < 0) begin
                if (bus_i.framebuffer !== prev) early = 1'b1;
                if (bus_i.busy !== 1'b1) gap = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_i.start = 1'b0; bus_i.values = '0; bus_i.xpos = '0; bus_i.ypos = '0; bus_i.enable = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_i.framebuffer !== '0) begin errors++; $display("FAIL reset_fb got nonzero want 0"); end
        checks++; if (bus_i.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus_i.busy); end
        checks++; if (bus_i.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_i.done); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat, nd; bit early, gap;
        logic [FB-1:0] exp, fb;
        bus_i.enable = '0;
        set_sprite(0, 8'h6C, 6'd16, 5'd2, 1'b1);
        exp = model_now();
        render(1'b0, lat, nd, early, gap);
        fb = bus_i.framebuffer;
        checks++; if (lat !== LAT) begin errors++; $display("FAIL dir_latency got %0d want %0d", lat, LAT); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL dir_done_count got %0d want 1", nd); end
        checks++; if (early || gap) begin errors++; $display("FAIL dir_partial early=%b busy_gap=%b want 0 0", early, gap); end
        checks++; if (fb[98:96] !== 3'b111) begin errors++; $display("FAIL dir_bits98_96 got %b want 111", fb[98:96]); end
        checks++; if (fb[103:101] !== 3'b111) begin errors++; $display("FAIL dir_bits103_101 got %b want 111", fb[103:101]); end
        checks++; if (fb[138:136] !== 3'b001) begin errors++; $display("FAIL dir_bits138_136 got %b want 001", fb[138:136]); end
        checks++; if (fb[141] !== 1'b1) begin errors++; $display("FAIL dir_bit141 got %b want 1", fb[141]); end
        checks++; if (fb !== exp) begin errors++; $display("FAIL dir_frame got %h want %h", fb, exp); end
    endtask

    task automatic test_clip();
        int lat, nd; bit early, gap;
        logic [FB-1:0] exp;
        exp = '0;
        exp[28*W + 38] = 1'b1; exp[28*W + 39] = 1'b1; exp[29*W + 38] = 1'b1;
        bus_i.enable = '0;
        set_sprite(0, 8'h88, 6'd38, 5'd28, 1'b1);
        render(1'b0, lat, nd, early, gap);
        checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL clip_frame got %h want %h", bus_i.framebuffer, exp); end
        checks++; if (bus_i.framebuffer !== model_now()) begin errors++; $display("FAIL clip_model got %h want %h", bus_i.framebuffer, model_now()); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL clip_latency got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_overlap();
        int lat, nd; bit early, gap;
        bus_i.enable = '0;
        set_sprite(0, 8'h00, 6'd0, 5'd0, 1'b1);
        set_sprite(1, 8'h00, 6'd1, 5'd0, 1'b1);
        render(1'b0, lat, nd, early, gap);
        checks++; if (bus_i.framebuffer[8:0] !== 9'h1EF) begin errors++; $display("FAIL ovl_row0 got %h want 1ef", bus_i.framebuffer[8:0]); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL ovl_done_count got %0d want 1", nd); end
        checks++; if (bus_i.framebuffer !== model_now()) begin errors++; $display("FAIL ovl_frame got %h want %h", bus_i.framebuffer, model_now()); end
    endtask

    task automatic test_restart_ignored();
        int lat, nd; bit early, gap;
        logic [FB-1:0] exp;
        rand_inputs();
        exp = model_now();
        lat = -1; nd = 0;
        bus_i.start = 1'b1;
        @(posedge clk); #1;
        bus_i.start = 1'b0;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            @(posedge clk); #1;
            // Raise start so that it is sampled at edges 10 and 45 of the render.
            bus_i.start = (k == 9 || k == 44) ? 1'b1 : 1'b0;
            if (bus_i.done) begin nd++; lat = k; end
        end
        bus_i.start = 1'b0;
        checks++; if (lat !== LAT) begin errors++; $display("FAIL rst_ign_latency got %0d want %0d", lat, LAT); end
        checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL rst_ign_frame got %h want %h", bus_i.framebuffer, exp); end
        // One IDLE cycle follows done; a start raised now must be taken on the next edge.
        rand_inputs();
        exp = model_now();
        render(1'b0, lat, nd, early, gap);
        checks++; if (lat !== LAT || nd !== 1) begin errors++; $display("FAIL rst_ign_next got lat %0d dones %0d want %0d 1", lat, nd, LAT); end
        checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL rst_ign_next_frame got %h want %h", bus_i.framebuffer, exp); end
    endtask

    task automatic test_reset_midrender();
        int lat, nd; bit early, gap;
        logic [FB-1:0] prev, exp;
        prev = bus_i.framebuffer;
        rand_inputs();
        bus_i.start = 1'b1;
        @(posedge clk); #1;
        bus_i.start = 1'b0;
        repeat (H + 3) @(posedge clk);
        #3;
        checks++; if (bus_i.framebuffer !== prev || bus_i.busy !== 1'b1) begin errors++; $display("FAIL mid_before_reset busy %b want 1, frame held %b want 1", bus_i.busy, bus_i.framebuffer === prev); end
        rst = 1'b1;
        #1;
        checks++; if (bus_i.framebuffer !== '0) begin errors++; $display("FAIL mid_reset_fb got %h want 0", bus_i.framebuffer); end
        checks++; if (bus_i.busy !== 1'b0 || bus_i.done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags busy %b done %b want 0 0", bus_i.busy, bus_i.done); end
        @(posedge clk); #1;
        rst = 1'b0;
        rand_inputs();
        exp = model_now();
        render(1'b0, lat, nd, early, gap);
        checks++; if (lat !== LAT || nd !== 1) begin errors++; $display("FAIL mid_after got lat %0d dones %0d want %0d 1", lat, nd, LAT); end
        checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL mid_after_frame got %h want %h", bus_i.framebuffer, exp); end
    endtask

    task automatic test_input_change();
        int lat, nd; bit early, gap;
        logic [FB-1:0] exp;
        for (int it = 0; it < 3; it++) begin
            rand_inputs();
            bus_i.enable = '1;
            exp = model_now();
            render(1'b1, lat, nd, early, gap);
            checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL chg_frame[%0d] got %h want %h", it, bus_i.framebuffer, exp); end
        end
    endtask

    task automatic test_random();
        int lat, nd; bit early, gap;
        logic [FB-1:0] exp;
        for (int it = 0; it < 6; it++) begin
            rand_inputs();
            exp = model_now();
            render(1'b0, lat, nd, early, gap);
            checks++; if (bus_i.framebuffer !== exp) begin errors++; $display("FAIL rnd_frame[%0d] got %h want %h", it, bus_i.framebuffer, exp); end
            checks++; if (lat !== LAT || nd !== 1 || early || gap) begin errors++; $display("FAIL rnd_timing[%0d] lat %0d dones %0d early %b gap %b want %0d 1 0 0", it, lat, nd, early, gap, LAT); end
        end
    endtask

    task automatic test_hold();
        logic [FB-1:0] held;
        held = bus_i.framebuffer;
        rand_inputs();
        repeat (20) @(posedge clk);
        #1;
        checks++; if (bus_i.framebuffer !== held) begin errors++; $display("FAIL hold_frame got %h want %h", bus_i.framebuffer, held); end
        checks++; if (bus_i.busy !== 1'b0) begin errors++; $display("FAIL hold_busy got %b want 0", bus_i.busy); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clip();
        test_overlap();
        test_restart_ignored();
        test_reset_midrender();
        test_input_change();
        test_random();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
